// File: rtl/warp_issue_scheduler_pkg.sv
// Shared SM parameters and types for the warp issue scheduler.
// Holds warp count, warp index width and decoded packet width, plus the
// matching index/packet typedefs used by the scheduler and its bench.
package warp_issue_scheduler_pkg;

  localparam int unsigned NumWarp    = 8;
  localparam int unsigned NumWarpLog = 3;
  localparam int unsigned PktW       = 128;

  typedef logic [NumWarpLog-1:0] warp_idx_t;
  typedef logic [PktW-1:0]       pkt_t;

endpackage

// File: rtl/warp_issue_scheduler_rr_priority_pick.sv
// Round-robin priority picker shared by SM arbiters.
// Returns the first set request bit searching from ptr_i upward, wrapping
// modulo N (N must be a power of two so the index wraps by overflow).
//   req_i   in  N     request vector
//   ptr_i   in  IdxW  search start position
//   grant_o out IdxW  granted index (ptr_i when nothing requests)
//   any_o   out 1     any request present
module rr_priority_pick #(
  parameter int unsigned N    = 8,
  parameter int unsigned IdxW = 3
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] grant_o,
  output logic            any_o
);

  logic [IdxW-1:0] idx;

  assign any_o = |req_i;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    grant_o = ptr_i;
    idx     = ptr_i;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ptr_i + IdxW'(i);
      if (req_i[idx]) begin
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/warp_issue_scheduler.sv
// Per-SM warp issue scheduler. Buffers one decoded packet per warp, picks
// one eligible warp per cycle in round-robin order, offers it to the
// ScoreBoard and issues it when ready and not stalled. A warp that issues
// a branch stays blocked until its branch resolves.
//   clk, reset            clock, synchronous active-high reset
//   stall_i               downstream stall
//   fill_*_i              decode fill (valid, warp, packet, branch flag)
//   buf_free_o            per-warp buffer free
//   sb_valid/warp/packet  candidate offered to the ScoreBoard
//   sb_ready_i            ScoreBoard ready for the candidate (same cycle)
//   br_resolve_*_i        branch-resolution pulse and warp
//   issue_*_o             registered issue to operand collect
//   err_o                 sticky: fill dropped on an occupied buffer
module warp_issue_scheduler
  import warp_issue_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  fill_valid_i,
  input  logic [NumWarpLog-1:0] fill_warp_i,
  input  logic [PktW-1:0]       fill_packet_i,
  input  logic                  fill_branch_i,
  output logic [NumWarp-1:0]    buf_free_o,
  output logic                  sb_valid_o,
  output logic [NumWarpLog-1:0] sb_warp_o,
  output logic [PktW-1:0]       sb_packet_o,
  input  logic                  sb_ready_i,
  input  logic                  br_resolve_valid_i,
  input  logic [NumWarpLog-1:0] br_resolve_warp_i,
  output logic                  issue_valid_o,
  output logic [NumWarpLog-1:0] issue_warp_o,
  output logic [PktW-1:0]       issue_packet_o,
  output logic                  err_o
);

  logic [NumWarp-1:0] valid_q, valid_d;
  logic [NumWarp-1:0] blocked_q, blocked_d;
  logic [NumWarp-1:0] branch_q, branch_d;
  pkt_t               packet_q [NumWarp];
  pkt_t               packet_d [NumWarp];
  warp_idx_t          rr_ptr_q, rr_ptr_d;
  logic               issue_valid_q, issue_valid_d;
  warp_idx_t          issue_warp_q, issue_warp_d;
  pkt_t               issue_packet_q, issue_packet_d;
  logic               err_q, err_d;

  logic [NumWarp-1:0] eligible;
  warp_idx_t          cand;
  logic               any_elig;
  logic               fire;
  logic               fill_ok;

  assign eligible = valid_q & ~blocked_q;

  rr_priority_pick #(
    .N    (NumWarp),
    .IdxW (NumWarpLog)
  ) u_pick (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .grant_o (cand),
    .any_o   (any_elig)
  );

  // Same condition the ScoreBoard uses to reserve the destination.
  assign fire    = any_elig & sb_ready_i & ~stall_i;
  // A buffer draining this cycle may be refilled in the same cycle.
  assign fill_ok = ~valid_q[fill_warp_i] | (fire & (cand == fill_warp_i));

  always_comb begin
    valid_d        = valid_q;
    blocked_d      = blocked_q;
    branch_d       = branch_q;
    packet_d       = packet_q;
    rr_ptr_d       = rr_ptr_q;
    issue_valid_d  = fire;
    issue_warp_d   = issue_warp_q;
    issue_packet_d = issue_packet_q;
    err_d          = err_q;

    // Advance past the candidate whether or not it issued, so a hazarded
    // warp cannot starve the others.
    if (any_elig && !stall_i) begin
      rr_ptr_d = cand + 1'b1;
    end

    if (br_resolve_valid_i) begin
      blocked_d[br_resolve_warp_i] = 1'b0;
    end

    if (fire) begin
      valid_d[cand]  = 1'b0;
      issue_warp_d   = cand;
      issue_packet_d = packet_q[cand];
      if (branch_q[cand]) begin
        blocked_d[cand] = 1'b1;
      end
    end

    if (fill_valid_i) begin
      if (fill_ok) begin
        valid_d[fill_warp_i]  = 1'b1;
        packet_d[fill_warp_i] = fill_packet_i;
        branch_d[fill_warp_i] = fill_branch_i;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q        <= '0;
      blocked_q      <= '0;
      branch_q       <= '0;
      for (int i = 0; i < NumWarp; i++) begin
        packet_q[i] <= '0;
      end
      rr_ptr_q       <= '0;
      issue_valid_q  <= 1'b0;
      issue_warp_q   <= '0;
      issue_packet_q <= '0;
      err_q          <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      blocked_q      <= blocked_d;
      branch_q       <= branch_d;
      packet_q       <= packet_d;
      rr_ptr_q       <= rr_ptr_d;
      issue_valid_q  <= issue_valid_d;
      issue_warp_q   <= issue_warp_d;
      issue_packet_q <= issue_packet_d;
      err_q          <= err_d;
    end
  end

  assign buf_free_o     = ~valid_q;
  assign sb_valid_o     = any_elig;
  assign sb_warp_o      = cand;
  assign sb_packet_o    = packet_q[cand];
  assign issue_valid_o  = issue_valid_q;
  assign issue_warp_o   = issue_warp_q;
  assign issue_packet_o = issue_packet_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Self-checking bench for warp_issue_scheduler. Expected issues are queued
// as stimulus is applied and compared as issue_valid_o pulses appear.
module tb_warp_issue_scheduler;
  import warp_issue_scheduler_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  stall_i;
  logic                  fill_valid_i;
  logic [NumWarpLog-1:0] fill_warp_i;
  logic [PktW-1:0]       fill_packet_i;
  logic                  fill_branch_i;
  logic [NumWarp-1:0]    buf_free_o;
  logic                  sb_valid_o;
  logic [NumWarpLog-1:0] sb_warp_o;
  logic [PktW-1:0]       sb_packet_o;
  logic                  sb_ready_i;
  logic                  br_resolve_valid_i;
  logic [NumWarpLog-1:0] br_resolve_warp_i;
  logic                  issue_valid_o;
  logic [NumWarpLog-1:0] issue_warp_o;
  logic [PktW-1:0]       issue_packet_o;
  logic                  err_o;

  // ScoreBoard stand-in: ready unless the candidate is the hazarded warp.
  logic                  ready_all;
  logic                  hz_en;
  logic [NumWarpLog-1:0] hz_warp;
  assign sb_ready_i = ready_all & ~(hz_en & (sb_warp_o == hz_warp));

  warp_issue_scheduler u_dut (
    .clk                (clk),
    .reset              (reset),
    .stall_i            (stall_i),
    .fill_valid_i       (fill_valid_i),
    .fill_warp_i        (fill_warp_i),
    .fill_packet_i      (fill_packet_i),
    .fill_branch_i      (fill_branch_i),
    .buf_free_o         (buf_free_o),
    .sb_valid_o         (sb_valid_o),
    .sb_warp_o          (sb_warp_o),
    .sb_packet_o        (sb_packet_o),
    .sb_ready_i         (sb_ready_i),
    .br_resolve_valid_i (br_resolve_valid_i),
    .br_resolve_warp_i  (br_resolve_warp_i),
    .issue_valid_o      (issue_valid_o),
    .issue_warp_o       (issue_warp_o),
    .issue_packet_o     (issue_packet_o),
    .err_o              (err_o)
  );

  always #5 clk = ~clk;

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;
  logic [130:0] exp_q [$];

  task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fill(input logic v, input int w, input logic [PktW-1:0] p, input logic b);
    fill_valid_i  = v;
    fill_warp_i   = NumWarpLog'(w);
    fill_packet_i = p;
    fill_branch_i = b;
  endtask

  task automatic push_exp(input int w, input logic [PktW-1:0] p);
    exp_q.push_back({NumWarpLog'(w), p});
  endtask

  function automatic logic [PktW-1:0] rnd_pkt();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Issue monitor: every issue pulse must match the oldest expected issue.
  always @(posedge clk) begin
    #1;
    if (!reset && issue_valid_o) begin
      if (exp_q.size() == 0) begin
        check("issue_unexpected", 132'({issue_warp_o, issue_packet_o}), 132'(0));
      end else begin
        check("issue", 132'({issue_warp_o, issue_packet_o}), 132'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [PktW-1:0] pk [NumWarp];
  logic [PktW-1:0] pa, pb, pc;
  int              t1 [3] = '{0, 3, 5};

  initial begin
    reset = 1'b1; stall_i = 1'b0;
    set_fill(1'b0, 0, '0, 1'b0);
    br_resolve_valid_i = 1'b0; br_resolve_warp_i = '0;
    ready_all = 1'b1; hz_en = 1'b0; hz_warp = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_buf_free", 132'(buf_free_o), 132'(8'hFF));
    check("rst_sb_valid", 132'(sb_valid_o), 132'(0));
    check("rst_issue_valid", 132'(issue_valid_o), 132'(0));
    check("rst_issue_warp", 132'(issue_warp_o), 132'(0));
    check("rst_issue_packet", 132'(issue_packet_o), 132'(0));
    check("rst_err", 132'(err_o), 132'(0));

    // Fill 0, 3, 5 under stall, then issue them back to back.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pk[t1[i]] = rnd_pkt();
      set_fill(1'b1, t1[i], pk[t1[i]], 1'b0);
      tick();
    end
    set_fill(1'b0, 0, '0, 1'b0);
    check("t1_sb_valid", 132'(sb_valid_o), 132'(1));
    check("t1_sb_warp", 132'(sb_warp_o), 132'(0));
    check("t1_sb_packet", 132'(sb_packet_o), 132'(pk[0]));
    check("t1_buf_free", 132'(buf_free_o), 132'(8'hD6));
    for (int i = 0; i < 3; i++) push_exp(t1[i], pk[t1[i]]);
    stall_i = 1'b0;
    tick(); tick(); tick(); tick();
    check("t1_buf_free_end", 132'(buf_free_o), 132'(8'hFF));
    check("t1_sb_valid_end", 132'(sb_valid_o), 132'(0));

    // Warp 1 hazarded: it is skipped, warp 2 issues, then 1 comes back.
    stall_i = 1'b1;
    pk[1] = rnd_pkt(); set_fill(1'b1, 1, pk[1], 1'b0); tick();
    pk[2] = rnd_pkt(); set_fill(1'b1, 2, pk[2], 1'b0); tick();
    set_fill(1'b0, 0, '0, 1'b0);
    hz_en = 1'b1; hz_warp = 3'd1; stall_i = 1'b0;
    check("t2_cand1", 132'(sb_warp_o), 132'(1));
    tick();
    check("t2_cand2", 132'(sb_warp_o), 132'(2));
    check("t2_no_issue", 132'(issue_valid_o), 132'(0));
    push_exp(2, pk[2]);
    tick();
    check("t2_cand1_again", 132'(sb_warp_o), 132'(1));
    check("t2_buf_free", 132'(buf_free_o), 132'(8'hFD));
    hz_en = 1'b0;
    push_exp(1, pk[1]);
    tick(); tick();
    check("t2_buf_free_end", 132'(buf_free_o), 132'(8'hFF));

    // Stall holds the pointer: warp 4 stays candidate over warp 1.
    stall_i = 1'b1;
    pk[4] = rnd_pkt(); set_fill(1'b1, 4, pk[4], 1'b0); tick();
    pk[1] = rnd_pkt(); set_fill(1'b1, 1, pk[1], 1'b0); tick();
    set_fill(1'b0, 0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t3_stall_cand", 132'(sb_warp_o), 132'(4));
      check("t3_stall_no_issue", 132'(issue_valid_o), 132'(0));
      tick();
    end
    push_exp(4, pk[4]); push_exp(1, pk[1]);
    stall_i = 1'b0;
    tick(); tick(); tick();
    check("t3_buf_free_end", 132'(buf_free_o), 132'(8'hFF));

    // Branch on warp 2 blocks its refilled packet until resolve.
    stall_i = 1'b1;
    pb = rnd_pkt(); set_fill(1'b1, 2, pb, 1'b1); tick();
    set_fill(1'b0, 0, '0, 1'b0);
    stall_i = 1'b0;
    push_exp(2, pb);
    tick();
    pa = rnd_pkt(); set_fill(1'b1, 2, pa, 1'b0); tick();
    set_fill(1'b0, 0, '0, 1'b0);
    check("t4_refilled", 132'(buf_free_o), 132'(8'hFB));
    for (int i = 0; i < 4; i++) begin
      check("t4_blocked", 132'(sb_valid_o), 132'(0));
      tick();
    end
    br_resolve_valid_i = 1'b1; br_resolve_warp_i = 3'd2;
    tick();
    br_resolve_valid_i = 1'b0;
    check("t4_resolved_valid", 132'(sb_valid_o), 132'(1));
    check("t4_resolved_warp", 132'(sb_warp_o), 132'(2));
    push_exp(2, pa);
    tick(); tick();
    check("t4_buf_free_end", 132'(buf_free_o), 132'(8'hFF));

    // Fill to an occupied buffer is dropped; fill during its issue is taken.
    stall_i = 1'b1;
    pa = rnd_pkt(); set_fill(1'b1, 6, pa, 1'b0); tick();
    check("t5_err_clear", 132'(err_o), 132'(0));
    pb = rnd_pkt(); set_fill(1'b1, 6, pb, 1'b0); tick();
    check("t5_err_set", 132'(err_o), 132'(1));
    check("t5_buf_free", 132'(buf_free_o), 132'(8'hBF));
    stall_i = 1'b0;
    pc = rnd_pkt(); set_fill(1'b1, 6, pc, 1'b0);
    push_exp(6, pa);
    tick();
    set_fill(1'b0, 0, '0, 1'b0);
    check("t5_err_sticky", 132'(err_o), 132'(1));
    check("t5_refill_taken", 132'(buf_free_o), 132'(8'hBF));
    push_exp(6, pc);
    tick(); tick();
    check("t5_buf_free_end", 132'(buf_free_o), 132'(8'hFF));

    // Mid-operation reset clears buffered, blocked and error state.
    stall_i = 1'b1;
    pa = rnd_pkt(); set_fill(1'b1, 3, pa, 1'b1); tick();
    set_fill(1'b0, 0, '0, 1'b0);
    stall_i = 1'b0;
    push_exp(3, pa);
    tick();
    stall_i = 1'b1;
    set_fill(1'b1, 3, rnd_pkt(), 1'b0); tick();
    set_fill(1'b1, 5, rnd_pkt(), 1'b0); tick();
    set_fill(1'b0, 0, '0, 1'b0);
    check("t6_pre_reset", 132'(buf_free_o), 132'(8'hD7));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_buf_free", 132'(buf_free_o), 132'(8'hFF));
    check("t6_rst_sb_valid", 132'(sb_valid_o), 132'(0));
    check("t6_rst_err", 132'(err_o), 132'(0));
    check("t6_rst_issue", 132'(issue_valid_o), 132'(0));

    // All warps valid and always ready: grants 0..7 then wrap, refilling each.
    for (int w = 0; w < NumWarp; w++) begin
      pk[w] = rnd_pkt();
      set_fill(1'b1, w, pk[w], 1'b0);
      tick();
    end
    set_fill(1'b0, 0, '0, 1'b0);
    stall_i = 1'b0;
    for (int k = 0; k < 2 * NumWarp; k++) begin
      check("t7_grant", 132'(sb_warp_o), 132'(k % NumWarp));
      check("t7_valid", 132'(sb_valid_o), 132'(1));
      push_exp(k % NumWarp, pk[k % NumWarp]);
      if (k < NumWarp) begin
        pk[k] = rnd_pkt();
        set_fill(1'b1, k, pk[k], 1'b0);
      end else begin
        set_fill(1'b0, 0, '0, 1'b0);
      end
      tick();
    end
    set_fill(1'b0, 0, '0, 1'b0);
    tick(); tick();
    check("t7_buf_free_end", 132'(buf_free_o), 132'(8'hFF));
    check("sb_drain", 132'(exp_q.size()), 132'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/warp_issue_scheduler.md
# warp_issue_scheduler

Per-SM warp issue scheduler between the decode stage and the ScoreBoard/operand-collect stage. It holds one decoded instruction packet per warp and picks one eligible warp per cycle in round-robin order. It presents that warp's packet to the ScoreBoard check port and issues it downstream when the ScoreBoard reports ready and the pipe is not stalled. Warps that issue a branch are blocked until the branch resolves.

## Interface
- NUM_WARP, 8: warps per SM; power of two.
- NUM_WARP_LOG, 3: log2(NUM_WARP).
- PKT_W, 128: decoded packet width; same layout as the ScoreBoard check packet.

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- stall_i  in  1  downstream stall; no issue while high.
- fill_valid_i  in  1  decode delivers a packet.
- fill_warp_i  in  NUM_WARP_LOG  target warp buffer.
- fill_packet_i  in  PKT_W  decoded packet.
- fill_branch_i  in  1  packet is a control-flow instruction.
- buf_free_o  out  NUM_WARP  per-warp buffer free (registered).
- sb_valid_o  out  1  candidate present; drives ScoreBoard toSelectPacketValid_i.
- sb_warp_o  out  NUM_WARP_LOG  candidate warp; drives ScoreBoard toSelectWarp_i.
- sb_packet_o  out  PKT_W  candidate packet; drives ScoreBoard toSelectPacket_i.
- sb_ready_i  in  1  ScoreBoard toSelectReady_o, combinational, same cycle.
- br_resolve_valid_i  in  1  branch-resolution pulse.
- br_resolve_warp_i  in  NUM_WARP_LOG  warp whose branch resolved.
- issue_valid_o  out  1  registered issue pulse to operand collect.
- issue_warp_o  out  NUM_WARP_LOG  issued warp.
- issue_packet_o  out  PKT_W  issued packet.
- err_o  out  1  sticky error: fill to an occupied buffer.

## Operation
- State per warp w:
  - valid[w] and packet[w] / branch[w]: one-entry buffer.
  - blocked[w]: branch outstanding.
- Global state: rr_ptr (NUM_WARP_LOG bits).
- Eligible[w] = valid[w] & ~blocked[w].
- Candidate c: the first eligible warp searching rr_ptr, rr_ptr+1, … mod NUM_WARP. This is combinational from registered state only.
  - sb_valid_o = |eligible.
  - sb_warp_o = c.
  - sb_packet_o = packet[c].
- Issue condition: fire = sb_valid_o & sb_ready_i & ~stall_i. This matches the ScoreBoard reservation condition, so a dest is reserved exactly when an issue occurs.
- On fire:
  - valid[c] <= 0.
  - issue_* <= {1, c, packet[c]}.
  - If branch[c], then blocked[c] <= 1.
  - rr_ptr <= c+1.
- On sb_valid_o & ~sb_ready_i & ~stall_i: rr_ptr <= c+1, so a hazarded warp cannot starve others. No issue.
- On stall_i:
  - rr_ptr holds.
  - issue_valid_o <= 0; issue_warp_o and issue_packet_o hold.
- Fill:
  - Accepted when buffer w is free, or is being issued this same cycle (fire & c==w).
  - Accepted fill sets valid, packet and branch.
  - Fill accepted during stall.
  - Fill to an occupied, non-issuing buffer: dropped, err_o <= 1.
- Branch resolve:
  - Clears blocked[br_resolve_warp_i].
  - Resolve for an unblocked warp: no effect.
  - A blocked warp's buffer may be refilled; the packet waits until resolve.
- Wrap-around: rr_ptr and c+1 wrap modulo NUM_WARP by natural overflow.
- buf_free_o[w] = ~valid[w] (registered view).

## Timing
- Reset values:
  - valid, blocked, branch all 0; rr_ptr 0.
  - issue_valid_o 0, issue_warp_o 0, issue_packet_o 0.
  - buf_free_o all 1s; err_o 0.
  - sb_valid_o 0 as a consequence.
- Reset asserted mid-operation discards all buffered and blocked state at the next edge.
- Fill to candidate-visible latency: 1 cycle. Fill at edge N; eligible and on sb_* in cycle N+1.
- Select to issue_valid_o latency: 1 cycle (registered).
- Back-to-back issue from different warps: every cycle. Same warp: every cycle if refilled in the issue cycle.
- Resolve at edge N: warp is eligible in cycle N+1. Resolve and fill for the same warp in the same cycle are both applied.
- At most one issue per cycle.

## Structure
- Shared package / GPGPUParam.v holds:
  - NUM_WARP, NUM_WARP_LOG.
  - Packet width macros.
  - The branch-flag position if derived from the packet instead of fill_branch_i.
- Sub-module rr_priority_pick (NUM_WARP-bit request vector plus pointer → grant index and any-valid). It is reused by other SM arbiters.

## Test plan
- Reset, then fill warps 0, 3, 5 with sb_ready_i=1 → issues in order 0, 3, 5 on consecutive cycles; rr_ptr ends at 6; buf_free_o=8'hFF.
- Warps 1 and 2 valid, sb_ready_i=0 for warp 1 only → cycle 1 candidate 1, not issued; cycle 2 candidate 2 issues; then candidate 1 again.
- stall_i=1 for 3 cycles with warp 4 valid and ready → no issue, rr_ptr holds, sb_warp_o=4 throughout; issue on the first unstalled cycle.
- Warp 2 issues a branch packet, is refilled, br_resolve at cycle +5 → warp 2 not candidate during cycles +1..+5; eligible from cycle +6.
- Fill warp 6 twice without an issue → second fill dropped, err_o=1 sticky; then fill in the same cycle as warp 6 issues → accepted, err_o unchanged.
- All 8 warps valid and always ready → grants 0..7 then wrap to 0, with no warp granted twice within 8 cycles.
